// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Pipeline register with a valid/ready handshake and a 2-entry skid buffer.
//   It passes one transfer per clock. in_ready depends only on registered
//   state and resetn, so it does not form a combinational path from out_ready.
//   Optional feature macro: PIPE_SKID_PERF_EN adds a saturating stall counter.
//
// Parameters
//   WIDTH      payload width in bits
//   RESET_VAL  value of out_data after reset
//
// Ports
//   clk        clock; all state updates on posedge
//   resetn     synchronous active-low reset
//   flush      synchronous discard of all held entries
//   in_valid   upstream has data
//   in_data    upstream payload
//   in_ready   block can accept in_data this cycle
//   out_valid  out_data holds a valid entry
//   out_data   oldest held entry (holds its last value when not valid)
//   out_ready  downstream consumes out_data this cycle
//   count      entries held: 0, 1 or 2
//   stall_cnt  (PIPE_SKID_PERF_EN only) cycles with out_valid & !out_ready

module pipe_skid_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;   // oldest entry, drives out_data
    logic [WIDTH-1:0] skid_q;   // second entry, only meaningful in FULL

    logic accept;
    logic fire;

    assign in_ready  = resetn && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    always_comb begin
        count = 2'd0;
        case (state)
            ONE:     count = 2'd1;
            FULL:    count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    // Flush only clears the valid state; main_q/skid_q keep their contents so
    // out_data keeps showing the last entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= EMPTY;
            main_q <= RESET_VAL;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q <= in_data;
                        state  <= FULL;
                    end else if (fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [31:0] stall_q;

    assign stall_cnt = stall_q;

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end
`endif

endmodule
